// File: rtl/complex_operand_loader.sv
`timescale 1ns/1ps
// complex_operand_loader
//
// Serial-to-parallel operand loader and result capture stage. It sits in
// front of the `complex` AND-OR reduction tree.
// - A framed serial stream is shifted into two operand registers, x and y.
//   Each operand is sent LSB first, x before y.
// - x and y are held stable on the tree inputs.
// - One cycle after the frame completes, the tree output is captured and
//   offered downstream.
// - Completed result handshakes are counted.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid and ready are both high. Neither side may make its valid
// depend on the other side's ready. An offered res_bit stays stable until
// it is accepted.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_bit / in_start are valid this cycle
//   in_ready   out  1      loader accepts a bit (high exactly in LOAD)
//   in_bit     in   1      serial data: x[0..W-1] then y[0..W-1]
//   in_start   in   1      marks the first bit of a frame
//   x, y       out  WIDTH  operand registers feeding complex.x / complex.y
//   cmp_out    in   1      complex.out, combinational in x / y
//   res_valid  out  1      res_bit holds a captured result
//   res_ready  in   1      downstream accepts the result
//   res_bit    out  1      captured cmp_out
//   err        out  1      one-cycle pulse when a frame is aborted early
//   frame_cnt  out  8      completed-result count, wraps 255 -> 0
//   state_dbg  out  2      current FSM state (0 LOAD, 1 EVAL, 2 RESULT)
//
// WIDTH must be at least 2.
module complex_operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_start,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  input  logic             cmp_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_bit,
  output logic             err,
  output logic [7:0]       frame_cnt,
  output logic [1:0]       state_dbg
);

  localparam int CW   = $clog2(2*WIDTH) + 1;
  localparam int IW   = $clog2(WIDTH);
  localparam int LAST = 2*WIDTH - 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    EVAL   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             res_bit_q, res_bit_d;
  logic             err_q, err_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic             accept;
  logic             in_x_half;
  logic [IW-1:0]    x_idx;
  logic [IW-1:0]    y_idx;

  assign in_ready  = (state_q == LOAD);
  assign res_valid = (state_q == RESULT);
  assign accept    = in_valid & in_ready;

  // Position of the incoming bit inside its operand.
  // Only the low IW bits matter because both offsets are below WIDTH.
  assign in_x_half = (cnt_q < CW'(WIDTH));
  assign x_idx     = IW'(cnt_q);
  assign y_idx     = IW'(cnt_q - CW'(WIDTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    res_bit_d   = res_bit_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (in_start) begin
            // Start always (re)opens a frame. A frame already in progress
            // is abandoned; bits it wrote stay in x/y until overwritten.
            x_d[0] = in_bit;
            cnt_d  = CW'(1);
            err_d  = (cnt_q != '0);
          end else if (cnt_q != '0) begin
            if (in_x_half) begin
              x_d[x_idx] = in_bit;
            end else begin
              y_d[y_idx] = in_bit;
            end
            if (cnt_q == CW'(LAST)) begin
              cnt_d   = '0;
              state_d = EVAL;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          // A bit that arrives with no open frame is silently dropped.
        end
      end

      EVAL: begin
        // x/y have been stable for a full cycle, so the tree has settled.
        res_bit_d = cmp_out;
        state_d   = RESULT;
      end

      RESULT: begin
        if (res_ready) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = LOAD;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      res_bit_q   <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_bit_q   <= res_bit_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign res_bit   = res_bit_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_complex_operand_loader.sv
`timescale 1ns/1ps
// Bench for complex_operand_loader.
// The operand tree is replaced by a small AND-OR stand-in. It is chosen so
// that the directed operand pairs give the required results:
//   05/05 -> 1, 01/01 -> 0, FF/00 -> 0, C3/FF -> 1
module tb_complex_operand_loader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_bit;
  logic         in_start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cmp_out;
  logic         res_valid;
  logic         res_ready;
  logic         res_bit;
  logic         err;
  logic [7:0]   frame_cnt;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  // Each entry is {x, y, expected result}.
  logic [2*W:0] exp_q[$];
  logic [2*W:0] exp_e;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- stand-in reduction tree ----------------
  function automatic logic tree_model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] m;
    m = a & b;
    return (m[0] & m[2]) | (m[1] & m[3]) | (m[4] & m[5]) | (m[6] & m[7]);
  endfunction

  assign cmp_out = tree_model(x, y);

  complex_operand_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_start  (in_start),
    .x         (x),
    .y         (y),
    .cmp_out   (cmp_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_bit   (res_bit),
    .err       (err),
    .frame_cnt (frame_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after a rising edge; outputs are read at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic s);
    in_valid = 1'b1;
    in_bit   = b;
    in_start = s;
    tick();
    in_valid = 1'b0;
    in_start = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_rest(input logic [7:0] xv, input logic [7:0] yv);
    logic [15:0] f;
    f = {yv, xv};
    for (int i = 1; i < 16; i++) begin
      drive_bit(f[i], 1'b0);
      check("err_quiet", err, 0);
    end
    exp_q.push_back({xv, yv, tree_model(xv, yv)});
  endtask

  task automatic send_frame(input logic [7:0] xv, input logic [7:0] yv, input logic exp_err);
    drive_bit(xv[0], 1'b1);
    check("err_at_start", err, exp_err);
    send_rest(xv, yv);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("idle_timeout", in_ready, 1);
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_bit"}, res_bit, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- scoreboard ----------------
  // A handshake visible at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("sb_res_bit", res_bit, exp_e[0]);
        check("sb_x", x, exp_e[2*W:W+1]);
        check("sb_y", y, exp_e[W:1]);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] xv;
    logic [7:0] yv;
    logic       exp_res;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_start  = 1'b0;
    res_ready = 1'b1;

    #12;
    check_reset_vals("rst0");
    tick();
    rst_n = 1'b1;

    // Stray bits without a start are dropped.
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b1, 1'b0);
      check("stray_err", err, 0);
      check("stray_x", x, 0);
      check("stray_state", state_dbg, 0);
    end

    // Frame 05/05: latency and handshake timing.
    send_frame(8'h05, 8'h05, 1'b0);
    check("e0_state_eval", state_dbg, 1);
    check("e0_res_valid", res_valid, 0);
    check("e0_in_ready", in_ready, 0);
    tick();
    check("e1_res_valid", res_valid, 1);
    check("e1_res_bit", res_bit, 1);
    check("e1_in_ready", in_ready, 0);
    tick();
    check("e2_in_ready", in_ready, 1);
    check("e2_res_valid", res_valid, 0);
    check("cnt_after_1", frame_cnt, 1);
    check("sb_drained_1", exp_q.size(), 0);

    send_frame(8'h01, 8'h01, 1'b0);
    wait_idle();
    check("res_0101", res_bit, 0);
    send_frame(8'hFF, 8'h00, 1'b0);
    wait_idle();
    check("res_ff00", res_bit, 0);
    send_frame(8'hC3, 8'hFF, 1'b0);
    wait_idle();
    check("res_c3ff", res_bit, 1);
    check("cnt_after_4", frame_cnt, 4);

    // Backpressure in RESULT.
    res_ready = 1'b0;
    exp_res = tree_model(8'hA5, 8'h3C);
    send_frame(8'hA5, 8'h3C, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_res_valid", res_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_res_bit", res_bit, exp_res);
      check("bp_x", x, 8'hA5);
      check("bp_y", y, 8'h3C);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_res_valid", res_valid, 0);
    check("cnt_after_5", frame_cnt, 5);
    check("sb_drained_bp", exp_q.size(), 0);

    // Early restart after 5 bits.
    drive_bit(1'b1, 1'b1);
    check("partial_err0", err, 0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("partial_err1", err, 0);
    send_frame(8'h05, 8'h05, 1'b1);
    wait_idle();
    check("restart_res", res_bit, 1);
    check("cnt_after_6", frame_cnt, 6);

    // Reset after 9 bits of a frame.
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    send_frame(8'h05, 8'h05, 1'b0);
    wait_idle();
    check("rst_mid_res", res_bit, 1);
    check("rst_mid_cnt", frame_cnt, 1);

    // Reset while holding a result.
    res_ready = 1'b0;
    send_frame(8'hC3, 8'hFF, 1'b0);
    tick();
    check("pre_rst_valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_result");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    send_frame(8'h01, 8'h01, 1'b0);
    wait_idle();
    check("rst_result_cnt", frame_cnt, 1);

    // 257 back-to-back frames from reset: counter wraps and ends at 1.
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int f = 1; f <= 257; f++) begin
      xv = 8'($urandom_range(0, 255));
      yv = 8'($urandom_range(0, 255));
      send_frame(xv, yv, 1'b0);
      wait_idle();
      if (f == 255) check("wrap_255", frame_cnt, 255);
      if (f == 256) check("wrap_0", frame_cnt, 0);
    end
    check("wrap_end", frame_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
